// File: rtl/iagc_mem_ctrl.sv
// IAGC memory controller: decimated sample capture, BRAM clean and valid/ready dump.
// Optional feature macro IAGC_DUMP_HEADER_EN: prefix every dump with a capture-length word.
module iagc_mem_ctrl #(
  parameter int STATUS_SIZE    = 4,
  parameter int ADDR_SIZE      = 12,
  parameter int DATA_SIZE      = 14,
  parameter int DECIMATOR_SIZE = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [STATUS_SIZE-1:0]    i_status,
  input  logic [ADDR_SIZE-1:0]      i_memory_size,
  input  logic [DECIMATOR_SIZE-1:0] i_decimator,
  input  logic                      i_adc_valid,
  input  logic [DATA_SIZE-1:0]      i_ref_data,
  input  logic [DATA_SIZE-1:0]      i_err_data,
  input  logic [DATA_SIZE-1:0]      i_ref_rdata,
  input  logic [DATA_SIZE-1:0]      i_err_rdata,
  input  logic                      i_tx_ready,
  output logic                      o_mem_we,
  output logic [ADDR_SIZE-1:0]      o_mem_addr,
  output logic [DATA_SIZE-1:0]      o_ref_wdata,
  output logic [DATA_SIZE-1:0]      o_err_wdata,
  output logic                      o_tx_valid,
  output logic [DATA_SIZE-1:0]      o_tx_data,
  output logic                      o_sample_end,
  output logic                      o_dump_end,
  output logic                      o_clean_end
);

  localparam logic [STATUS_SIZE-1:0] STAT_SAMPLE   = STATUS_SIZE'(3);
  localparam logic [STATUS_SIZE-1:0] STAT_DUMP_REF = STATUS_SIZE'(7);
  localparam logic [STATUS_SIZE-1:0] STAT_DUMP_ERR = STATUS_SIZE'(8);
  localparam logic [STATUS_SIZE-1:0] STAT_CLEAN    = STATUS_SIZE'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_CLEAN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_TX, S_DONE
  } state_t;

  state_t                    r_state, w_state_next;
  logic [STATUS_SIZE-1:0]    r_status, w_status_next;
  logic [ADDR_SIZE-1:0]      r_last, w_last_next;
  logic [ADDR_SIZE-1:0]      r_addr, w_addr_next;
  logic [DECIMATOR_SIZE-1:0] r_dmax, w_dmax_next;
  logic [DECIMATOR_SIZE-1:0] r_dcnt, w_dcnt_next;
  logic                      r_src_err, w_src_err_next;
  logic                      r_hdr, w_hdr_next;
  logic                      r_mem_we, w_mem_we_next;
  logic [ADDR_SIZE-1:0]      r_mem_addr, w_mem_addr_next;
  logic [DATA_SIZE-1:0]      r_ref_wdata, w_ref_wdata_next;
  logic [DATA_SIZE-1:0]      r_err_wdata, w_err_wdata_next;
  logic                      r_tx_valid, w_tx_valid_next;
  logic [DATA_SIZE-1:0]      r_tx_data, w_tx_data_next;
  logic                      r_sample_end, w_sample_end_next;
  logic                      r_dump_end, w_dump_end_next;
  logic                      r_clean_end, w_clean_end_next;
  logic                      w_abort;
  logic                      w_start;

  assign w_abort = (i_status != r_status);
  assign w_start = (i_status == STAT_SAMPLE) || (i_status == STAT_CLEAN) ||
                   (i_status == STAT_DUMP_REF) || (i_status == STAT_DUMP_ERR);

`ifdef IAGC_DUMP_HEADER_EN
  // Length is computed one bit wider than the address so size 0 can represent 2^ADDR_SIZE.
  localparam int LEN_W = (ADDR_SIZE + 1 > DATA_SIZE) ? ADDR_SIZE + 1 : DATA_SIZE;
  logic [LEN_W-1:0]     w_len;
  logic [DATA_SIZE-1:0] w_header;
  always_comb begin
    w_len    = (i_memory_size == '0) ? (LEN_W'(1) << ADDR_SIZE) : LEN_W'(i_memory_size);
    w_header = (w_len > LEN_W'({DATA_SIZE{1'b1}})) ? '1 : DATA_SIZE'(w_len);
  end
`endif

  always_comb begin
    w_state_next      = r_state;
    w_status_next     = r_status;
    w_last_next       = r_last;
    w_addr_next       = r_addr;
    w_dmax_next       = r_dmax;
    w_dcnt_next       = r_dcnt;
    w_src_err_next    = r_src_err;
    w_hdr_next        = r_hdr;
    w_mem_we_next     = 1'b0;
    w_mem_addr_next   = r_mem_addr;
    w_ref_wdata_next  = r_ref_wdata;
    w_err_wdata_next  = r_err_wdata;
    w_tx_valid_next   = r_tx_valid;
    w_tx_data_next    = r_tx_data;
    w_sample_end_next = 1'b0;
    w_dump_end_next   = 1'b0;
    w_clean_end_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_valid_next = 1'b0;
        if (w_start) begin
          w_status_next   = i_status;
          w_last_next     = i_memory_size - 1'b1;
          w_dmax_next     = (i_decimator == '0) ? '0 : i_decimator - 1'b1;
          w_dcnt_next     = '0;
          w_addr_next     = '0;
          w_mem_addr_next = '0;
          w_src_err_next  = (i_status == STAT_DUMP_ERR);
          if (i_status == STAT_SAMPLE) begin
            w_state_next = S_SAMPLE;
          end else if (i_status == STAT_CLEAN) begin
            w_state_next = S_CLEAN;
          end else begin
`ifdef IAGC_DUMP_HEADER_EN
            w_hdr_next      = 1'b1;
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = w_header;
            w_state_next    = S_DUMP_TX;
`else
            w_state_next    = S_DUMP_RD;
`endif
          end
        end
      end
      S_SAMPLE: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (i_adc_valid) begin
          if (r_dcnt == r_dmax) begin
            w_dcnt_next      = '0;
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = r_addr;
            w_ref_wdata_next = i_ref_data;
            w_err_wdata_next = i_err_data;
            if (r_addr == r_last) begin
              w_state_next      = S_DONE;
              w_sample_end_next = 1'b1;
            end else begin
              w_addr_next = r_addr + 1'b1;
            end
          end else begin
            w_dcnt_next = r_dcnt + 1'b1;
          end
        end
      end
      S_CLEAN: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = r_addr;
          w_ref_wdata_next = '0;
          w_err_wdata_next = '0;
          if (r_addr == r_last) begin
            w_state_next     = S_DONE;
            w_clean_end_next = 1'b1;
          end else begin
            w_addr_next = r_addr + 1'b1;
          end
        end
      end
      // o_mem_addr already holds r_addr here; read data arrives during DUMP_WAIT.
      S_DUMP_RD: begin
        w_state_next = w_abort ? S_IDLE : S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_tx_valid_next = 1'b1;
          w_tx_data_next  = r_src_err ? i_err_rdata : i_ref_rdata;
          w_state_next    = S_DUMP_TX;
        end
      end
      S_DUMP_TX: begin
        if (w_abort) begin
          w_tx_valid_next = 1'b0;
          w_hdr_next      = 1'b0;
          w_state_next    = S_IDLE;
        end else if (i_tx_ready) begin
          w_tx_valid_next = 1'b0;
          if (r_hdr) begin
            w_hdr_next   = 1'b0;
            w_state_next = S_DUMP_RD;
          end else if (r_addr == r_last) begin
            w_dump_end_next = 1'b1;
            w_state_next    = S_DONE;
          end else begin
            w_addr_next     = r_addr + 1'b1;
            w_mem_addr_next = r_addr + 1'b1;
            w_state_next    = S_DUMP_RD;
          end
        end
      end
      // Hold here until the FSM leaves the state that started us, so we never restart twice.
      S_DONE: begin
        if (w_abort) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_status     <= '0;
      r_last       <= '0;
      r_addr       <= '0;
      r_dmax       <= '0;
      r_dcnt       <= '0;
      r_src_err    <= 1'b0;
      r_hdr        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_ref_wdata  <= '0;
      r_err_wdata  <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_sample_end <= 1'b0;
      r_dump_end   <= 1'b0;
      r_clean_end  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_status     <= w_status_next;
      r_last       <= w_last_next;
      r_addr       <= w_addr_next;
      r_dmax       <= w_dmax_next;
      r_dcnt       <= w_dcnt_next;
      r_src_err    <= w_src_err_next;
      r_hdr        <= w_hdr_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_ref_wdata  <= w_ref_wdata_next;
      r_err_wdata  <= w_err_wdata_next;
      r_tx_valid   <= w_tx_valid_next;
      r_tx_data    <= w_tx_data_next;
      r_sample_end <= w_sample_end_next;
      r_dump_end   <= w_dump_end_next;
      r_clean_end  <= w_clean_end_next;
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_ref_wdata  = r_ref_wdata;
  assign o_err_wdata  = r_err_wdata;
  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;
  assign o_sample_end = r_sample_end;
  assign o_dump_end   = r_dump_end;
  assign o_clean_end  = r_clean_end;

endmodule

// File: tb/tb_iagc_mem_ctrl.sv
// Bench for iagc_mem_ctrl: operation table driven into the DUT, scoreboard of expected writes/words/pulses.
// Build with IAGC_DUMP_HEADER_EN defined to expect the dump header word.
module tb_iagc_mem_ctrl;
  localparam int SW  = 4;
  localparam int AW  = 4;
  localparam int DW  = 14;
  localparam int DCW = 4;
`ifdef IAGC_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           i_clock, i_reset, i_adc_valid, i_tx_ready;
  logic [SW-1:0]  i_status;
  logic [AW-1:0]  i_memory_size;
  logic [DCW-1:0] i_decimator;
  logic [DW-1:0]  i_ref_data, i_err_data, i_ref_rdata, i_err_rdata;
  logic           o_mem_we, o_tx_valid, o_sample_end, o_dump_end, o_clean_end;
  logic [AW-1:0]  o_mem_addr;
  logic [DW-1:0]  o_ref_wdata, o_err_wdata, o_tx_data;

  iagc_mem_ctrl #(.STATUS_SIZE(SW), .ADDR_SIZE(AW), .DATA_SIZE(DW), .DECIMATOR_SIZE(DCW)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_status(i_status), .i_memory_size(i_memory_size),
    .i_decimator(i_decimator), .i_adc_valid(i_adc_valid), .i_ref_data(i_ref_data),
    .i_err_data(i_err_data), .i_ref_rdata(i_ref_rdata), .i_err_rdata(i_err_rdata),
    .i_tx_ready(i_tx_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_ref_wdata(o_ref_wdata), .o_err_wdata(o_err_wdata), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .o_sample_end(o_sample_end), .o_dump_end(o_dump_end),
    .o_clean_end(o_clean_end)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Two BRAMs with one-cycle registered read, fed by the DUT's write/address ports.
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] err_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      err_mem[i] = '0;
    end
  end
  always @(posedge i_clock) begin
    if (o_mem_we) begin
      ref_mem[o_mem_addr] <= o_ref_wdata;
      err_mem[o_mem_addr] <= o_err_wdata;
    end
    i_ref_rdata <= ref_mem[o_mem_addr];
    i_err_rdata <= err_mem[o_mem_addr];
  end

  typedef enum int {EV_WR, EV_TX, EV_SEND, EV_DEND, EV_CEND} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       d0;
    int       d1;
  } ev_t;
  typedef enum int {OP_CLEAN, OP_SAMPLE, OP_DUMP} op_kind_t;
  typedef struct {
    op_kind_t kind;
    int       status;
    int       size;
    int       dec;
    int       nstr;
    int       abort_at;
    bit       toggle;
    int       exp_ev;
  } vec_t;

  ev_t           sbq[$];
  vec_t          tbl[9];
  int            checks, errors, ev_cnt;
  bit            end_seen, mon_en;
  bit            pv, pr;
  logic [DW-1:0] pd;
  int            exp_ref[16];
  int            exp_err[16];

  function automatic void push_ev(ev_kind_t k, int a, int d0, int d1);
    ev_t e;
    e.kind = k; e.addr = a; e.d0 = d0; e.d1 = d1;
    sbq.push_back(e);
  endfunction

  function automatic void check_ev(ev_kind_t k, int a, int d0, int d1);
    ev_t e;
    checks++;
    ev_cnt++;
    if (k != EV_WR && k != EV_TX) end_seen = 1'b1;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got addr=%0d d0=0x%0h d1=0x%0h required none", k.name(), a, d0, d1);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || (k == EV_WR && e.addr != a) || e.d0 != d0 || e.d1 != d1) begin
        errors++;
        $display("FAIL event got %s addr=%0d d0=0x%0h d1=0x%0h required %s addr=%0d d0=0x%0h d1=0x%0h",
                 k.name(), a, d0, d1, e.kind.name(), e.addr, e.d0, e.d1);
      end
    end
  endfunction

  function automatic void check_eq(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void monitor();
    if (pv && !pr) begin
      checks++;
      if (!(o_tx_valid && o_tx_data == pd)) begin
        errors++;
        $display("FAIL tx_hold got valid=%0b data=0x%0h required valid=1 data=0x%0h", o_tx_valid, o_tx_data, pd);
      end
    end
    pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
    if (o_mem_we) check_ev(EV_WR, int'(o_mem_addr), int'(o_ref_wdata), int'(o_err_wdata));
    if (o_tx_valid && i_tx_ready) check_ev(EV_TX, 0, int'(o_tx_data), 0);
    if (o_sample_end) check_ev(EV_SEND, 0, 0, 0);
    if (o_dump_end) check_ev(EV_DEND, 0, 0, 0);
    if (o_clean_end) check_ev(EV_CEND, 0, 0, 0);
  endfunction

  // Outputs are observed on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(negedge i_clock);
    if (mon_en) monitor();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wait_end(int bound);
    for (int c = 0; c < bound && !end_seen; c++) step();
    checks++;
    if (!end_seen) begin
      errors++;
      $display("FAIL end_pulse_timeout got none within %0d cycles required one", bound);
    end
  endtask

  task automatic run_op(vec_t v);
    int n, d, widx, hdr;
    bit aborted;
    n = (v.size == 0) ? 16 : v.size;
    ev_cnt = 0;
    end_seen = 1'b0;
    i_memory_size = AW'(v.size);
    i_decimator = DCW'(v.dec);
    case (v.kind)
      OP_CLEAN: begin
        for (int a = 0; a < n; a++) begin
          push_ev(EV_WR, a, 0, 0);
          exp_ref[a] = 0;
          exp_err[a] = 0;
        end
        push_ev(EV_CEND, 0, 0, 0);
        i_status = SW'(v.status);
        wait_end(200);
        repeat (5) step();
      end
      OP_SAMPLE: begin
        d = (v.dec == 0) ? 1 : v.dec;
        widx = 0;
        aborted = 1'b0;
        i_status = SW'(v.status);
        step(); step();
        for (int k = 1; k <= v.nstr; k++) begin
          if (!aborted && v.abort_at != 0 && widx == v.abort_at) begin
            i_status = 4'd2;
            aborted = 1'b1;
          end
          i_ref_data = DW'(32'h100 + k - 1);
          i_err_data = DW'(32'h200 + k - 1);
          i_adc_valid = 1'b1;
          if (!aborted && (k % d) == 0 && widx < n) begin
            push_ev(EV_WR, widx, 32'h100 + k - 1, 32'h200 + k - 1);
            exp_ref[widx] = 32'h100 + k - 1;
            exp_err[widx] = 32'h200 + k - 1;
            widx++;
            if (widx == n) push_ev(EV_SEND, 0, 0, 0);
          end
          step();
          i_adc_valid = 1'b0;
          step();
        end
        if (!aborted) wait_end(20);
        repeat (4) step();
      end
      default: begin
        hdr = (v.size == 0) ? 16 : v.size;
        if (HDR != 0) push_ev(EV_TX, 0, hdr, 0);
        for (int a = 0; a < n; a++)
          push_ev(EV_TX, 0, (v.status == 8) ? exp_err[a] : exp_ref[a], 0);
        push_ev(EV_DEND, 0, 0, 0);
        i_status = SW'(v.status);
        i_tx_ready = 1'b0;
        for (int c = 0; c < 300 && !end_seen; c++) begin
          i_tx_ready = v.toggle ? ~i_tx_ready : 1'b1;
          step();
        end
        checks++;
        if (!end_seen) begin
          errors++;
          $display("FAIL dump_timeout got no o_dump_end required one");
        end
        i_tx_ready = 1'b0;
        repeat (4) step();
      end
    endcase
    i_status = '0;
    repeat (3) step();
    check_eq($sformatf("event_count_op_%s", v.kind.name()), ev_cnt,
             v.exp_ev + ((v.kind == OP_DUMP) ? HDR : 0));
    check_eq("scoreboard_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    //         kind       st size dec nstr abort toggle exp_ev
    tbl[0] = '{OP_CLEAN,  9, 8,   0,  0,   0,    1'b0,  9};
    tbl[1] = '{OP_SAMPLE, 3, 4,   3,  12,  0,    1'b0,  5};
    tbl[2] = '{OP_DUMP,   7, 4,   0,  0,   0,    1'b1,  5};
    tbl[3] = '{OP_DUMP,   8, 4,   0,  0,   0,    1'b1,  5};
    tbl[4] = '{OP_SAMPLE, 3, 4,   1,  8,   2,    1'b0,  2};
    tbl[5] = '{OP_DUMP,   7, 4,   0,  0,   0,    1'b0,  5};
    tbl[6] = '{OP_SAMPLE, 3, 2,   0,  3,   0,    1'b0,  3};
    tbl[7] = '{OP_CLEAN,  9, 0,   0,  0,   0,    1'b0,  17};
    tbl[8] = '{OP_DUMP,   8, 0,   0,  0,   0,    1'b1,  17};
    checks = 0; errors = 0; ev_cnt = 0;
    end_seen = 1'b0; mon_en = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int i = 0; i < 16; i++) begin
      exp_ref[i] = 0;
      exp_err[i] = 0;
    end
    i_reset = 1'b1; i_status = '0; i_memory_size = '0; i_decimator = '0;
    i_adc_valid = 1'b0; i_ref_data = '0; i_err_data = '0; i_tx_ready = 1'b0;
    repeat (3) step();
    i_reset = 1'b0;
    step();

    // Reset in the middle of a clean must silence every output at once.
    i_status = 4'd9; i_memory_size = 4'd8;
    repeat (4) step();
    check_eq("clean_running_we", int'(o_mem_we), 1);
    i_reset = 1'b1;
    step();
    check_eq("reset_mem_we", int'(o_mem_we), 0);
    check_eq("reset_mem_addr", int'(o_mem_addr), 0);
    check_eq("reset_tx_valid", int'(o_tx_valid), 0);
    check_eq("reset_clean_end", int'(o_clean_end), 0);
    check_eq("reset_sample_end", int'(o_sample_end), 0);
    check_eq("reset_dump_end", int'(o_dump_end), 0);
    i_reset = 1'b0; i_status = '0;
    step(); step();
    check_eq("idle_after_reset_we", int'(o_mem_we), 0);
    check_eq("idle_after_reset_clean_end", int'(o_clean_end), 0);

    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
